issue_scoreboard: RTL
=====================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the stall counter.
REQ-002 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  block accepts instruction this cycle.
REQ-007 in_readAddr1, in_readAddr2, in_writeAddr  input  5 each  source/destination register numbers.
REQ-008 in_uses1, in_uses2, in_regWrite  input  1 each  source 1 used, source 2 used, destination written.
REQ-009 wb_valid  input  1  writeback completes this cycle; wb_addr  input  5  register written back.
REQ-010 out_valid  output  1; out_ready  input  1  handshake to the register read/write stage.
REQ-011 out_readAddr1, out_readAddr2, out_writeAddr  output  5 each; out_regWrite  output  1  registered copy of the issued instruction.
REQ-012 stall_count  output  STALL_CNT_W  cycles lost to hazards or backpressure.

Function
REQ-013 The block SHALL hold busy[31:0]; busy[31] (XZR) SHALL read 0 always and never be set.
REQ-014 hazard SHALL = (in_uses1 & busy[in_readAddr1]) | (in_uses2 & busy[in_readAddr2]) | (in_regWrite & busy[in_writeAddr]) (RAW and WAW).
REQ-015 in_ready SHALL = !hazard & (!out_valid | out_ready), combinational; it SHALL NOT depend on in_valid.
REQ-016 Accept SHALL = in_valid & in_ready; on accept, out_* SHALL load the in_* fields and out_valid SHALL be 1 in the next cycle (latency 1).
REQ-017 out_* and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-018 When out_valid & out_ready and no accept occurs, out_valid SHALL fall to 0 next cycle; out_* fields SHALL hold.
REQ-019 On accept with in_regWrite=1 and in_writeAddr!=31, busy[in_writeAddr] SHALL be 1 next cycle.
REQ-020 wb_valid=1 SHALL clear busy[wb_addr] next cycle; wb to a non-busy register or to 31 SHALL be ignored.
REQ-021 Same-cycle set and clear of the same register SHALL leave busy=1 (set wins).
REQ-022 Same-cycle set and clear of different registers SHALL both take effect.
REQ-023 stall_count SHALL increment by 1 each cycle with in_valid & !in_ready, saturating at all-ones (no wrap).
REQ-024 Back-to-back accepts SHALL sustain one instruction per cycle when no hazard and out_ready=1.

Reset
REQ-025 reset_n=0 SHALL immediately clear busy, out_valid, out_* fields, and stall_count to 0, regardless of clk.
REQ-026 Reset mid-operation SHALL discard the held instruction and all pending busy bits; first accept is possible in the first cycle after reset_n rises.

Configuration
REQ-027 Macro SCOREBOARD_WB_BYPASS_EN defined: hazard SHALL use busy & ~(wb_valid ? onehot(wb_addr) : 0), so an instruction waiting on a register issues in the same cycle as its writeback.
REQ-028 Macro SCOREBOARD_WB_BYPASS_EN undefined: hazard SHALL use the registered busy only; the waiting instruction issues one cycle after the writeback.

Verification
REQ-029 Reset, then in_valid=1, writeAddr=5, regWrite=1, out_ready=1 -> out_valid=1, out_writeAddr=5 next cycle; busy[5]=1.
REQ-030 Busy[5] set, then instruction with readAddr1=5, uses1=1 -> in_ready=0, stall_count increments per cycle; wb_valid with wb_addr=5 -> issue one cycle later (bypass off) or same cycle (bypass on).
REQ-031 writeAddr=31, regWrite=1 accepted, then readAddr1=31 -> no stall, busy[31]=0.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> new instruction accepted the same cycle.
REQ-033 STALL_CNT_W=4, 20 stalled cycles -> stall_count=15 and holds.
REQ-034 reset_n pulsed low mid-stall with busy[7]=1 -> all outputs 0 asynchronously; instruction reading register 7 is accepted in the first cycle after release.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//
// Register scoreboard sitting between decode and register read. It tracks
// which architectural registers have a write in flight (busy bits), blocks
// any decoded instruction that would read or overwrite a busy register
// (RAW / WAW), and presents accepted instructions downstream through a
// single-entry valid/ready output register.
//
// Register 31 is the zero register: it is never marked busy, so reads and
// writes of it never stall.
//
// Build option:
//   SCOREBOARD_WB_BYPASS_EN  when defined, a writeback in the current cycle
//                            masks its busy bit out of the hazard check so a
//                            waiting instruction issues in the same cycle as
//                            the writeback. When undefined, only the
//                            registered busy bits are used and the waiting
//                            instruction issues one cycle later.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   in_valid / in_ready             decode-side handshake (in_ready is
//                                   independent of in_valid)
//   in_readAddr1/2, in_writeAddr    source / destination register numbers
//   in_uses1/2, in_regWrite         which of those fields are live
//   wb_valid, wb_addr               writeback completion, clears busy bit
//   out_valid / out_ready           handshake to register read/write stage
//   out_readAddr1/2, out_writeAddr,
//   out_regWrite                    registered copy of issued instruction
//   stall_count                     saturating count of cycles with
//                                   in_valid & !in_ready

module issue_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_readAddr1,
    input  logic [4:0]             in_readAddr2,
    input  logic [4:0]             in_writeAddr,
    input  logic                   in_uses1,
    input  logic                   in_uses2,
    input  logic                   in_regWrite,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_readAddr1,
    output logic [4:0]             out_readAddr2,
    output logic [4:0]             out_writeAddr,
    output logic                   out_regWrite,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [4:0] XZR = 5'd31;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [31:0]            busy_q, busy_d;
    logic [31:0]            wb_mask;
    logic [31:0]            busy_eff;
    logic                   hazard;
    logic                   accept;

    logic                   out_valid_q, out_valid_d;
    logic [4:0]             out_ra1_q, out_ra1_d;
    logic [4:0]             out_ra2_q, out_ra2_d;
    logic [4:0]             out_wa_q, out_wa_d;
    logic                   out_rw_q, out_rw_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    assign wb_mask = wb_valid ? (32'd1 << wb_addr) : 32'd0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign hazard = (in_uses1    & busy_eff[in_readAddr1])
                  | (in_uses2    & busy_eff[in_readAddr2])
                  | (in_regWrite & busy_eff[in_writeAddr]);

    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Clear first, then set: a same-cycle set and clear of one register
    // leaves it busy, since the new writer is still outstanding.
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (accept && in_regWrite && (in_writeAddr != XZR)) begin
            busy_d[in_writeAddr] = 1'b1;
        end
        busy_d[31] = 1'b0;
    end

    // Fields hold after the downstream handshake drains; only out_valid drops.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ra1_d   = out_ra1_q;
        out_ra2_d   = out_ra2_q;
        out_wa_d    = out_wa_q;
        out_rw_d    = out_rw_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_ra1_d   = in_readAddr1;
            out_ra2_d   = in_readAddr2;
            out_wa_d    = in_writeAddr;
            out_rw_d    = in_regWrite;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_ra1_q   <= '0;
            out_ra2_q   <= '0;
            out_wa_q    <= '0;
            out_rw_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_ra1_q   <= out_ra1_d;
            out_ra2_q   <= out_ra2_d;
            out_wa_q    <= out_wa_d;
            out_rw_q    <= out_rw_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_readAddr1 = out_ra1_q;
    assign out_readAddr2 = out_ra2_q;
    assign out_writeAddr = out_wa_q;
    assign out_regWrite  = out_rw_q;
    assign stall_count   = stall_q;

endmodule
